// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences a shared-memory datapath (one memory port, one ALU)
// through fetch/decode/execute states, driving every datapath enable and mux select.
module multicycle_controller #(
  parameter logic [6:0] HALT_OPCODE = 7'b1110011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       halted
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER,
    EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, HALT
  } state_t;

  state_t state_q, state_d;
  state_t curState;
  logic [2:0] aluOp;
  logic unusedFunct7;

  assign unusedFunct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          default:           state_d = (opcode == HALT_OPCODE) ? HALT : FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JALR:     state_d = JAL;
      JAL:      state_d = ALUWB;
      LUI:      state_d = ALUWB;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // Shared R/I funct3 decode; only register-register ops may subtract
  always_comb begin
    aluOp = ALU_ADD;
    case (funct3)
      3'b000:  aluOp = (state_q == EXECUTER && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  aluOp = ALU_SLT;
      3'b100:  aluOp = ALU_XOR;
      3'b110:  aluOp = ALU_OR;
      3'b111:  aluOp = ALU_AND;
      default: aluOp = ALU_ADD;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Reset shows FETCH selects immediately but holds every enable low
  always_comb begin
    curState   = rst ? FETCH : state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    halted     = 1'b0;
    case (curState)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = aluOp;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = aluOp;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

endmodule
